// File: rtl/nios2_debug_scan_pkg.sv
// rtl/nios2_debug_scan_pkg.sv - shared types and constants for the Nios II debug scan master
package nios2_debug_scan_pkg;

    localparam int SR_WIDTH_DEF = 38;
    localparam int IR_WIDTH_DEF = 2;

    // Width of a counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int bit_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BIT_CNT_W = bit_cnt_width(SR_WIDTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RSP
    } scan_state_e;

endpackage

// File: rtl/nios2_debug_scan_master_if.sv
// rtl/nios2_debug_scan_master_if.sv - command/response and virtual-JTAG signal bundle
// master modport: the scan master (drives cmd_ready, rsp_*, vjm_* toward the debug slave)
// slave modport : the host plus the debug slave (drives cmd_*, rsp_ready, vjm_tdo, vjm_ir_out)
interface nios2_debug_scan_master_if #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [SR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;
    logic                vjm_tck;
    logic                vjm_tdi;
    logic                vjm_tdo;
    logic [IR_WIDTH-1:0] vjm_ir_in;
    logic [IR_WIDTH-1:0] vjm_ir_out;
    logic                vjm_rti;
    logic                vjm_uir;
    logic                vjm_cdr;
    logic                vjm_sdr;
    logic                vjm_udr;

    modport master (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vjm_tdo, vjm_ir_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        output vjm_tck, vjm_tdi, vjm_ir_in, vjm_rti, vjm_uir, vjm_cdr, vjm_sdr, vjm_udr
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready, vjm_tdo, vjm_ir_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
        input  vjm_tck, vjm_tdi, vjm_ir_in, vjm_rti, vjm_uir, vjm_cdr, vjm_sdr, vjm_udr
    );
endinterface

// File: rtl/nios2_debug_scan_tck_gen.sv
// rtl/nios2_debug_scan_tck_gen.sv - tck phase counter with rise/fall/end-of-period strobes
// Ports: clk, reset_n (async active-low); i_run enables counting (phase held at 0 otherwise);
//        o_tck generated clock; o_fall at phase 0; o_rise at phase TCK_DIV; o_last at final phase.
module nios2_debug_scan_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    output logic o_tck,
    output logic o_rise,
    output logic o_fall,
    output logic o_last
);
    localparam int PERIOD = 2 * TCK_DIV;
    localparam int PW     = $clog2(PERIOD);

    logic [PW-1:0] r_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (!i_run || o_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_last = i_run && (r_phase == PW'(PERIOD - 1));
    assign o_rise = i_run && (r_phase == PW'(TCK_DIV));
    assign o_fall = i_run && (r_phase == '0);
    assign o_tck  = i_run && (r_phase >= PW'(TCK_DIV));

endmodule

// File: rtl/nios2_debug_scan_master.sv
// rtl/nios2_debug_scan_master.sv - virtual-JTAG scan initiator for the Nios II debug slave
// Ports: clk, reset_n (async active-low); bus (nios2_debug_scan_master_if.master) carrying
//        the cmd/rsp handshakes and the vjm_* virtual-JTAG signals.
// Option: NIOS2_DEBUG_SCAN_SKIP_IR_EN skips update-IR when the IR matches the last one loaded.
module nios2_debug_scan_master
    import nios2_debug_scan_pkg::*;
#(
    parameter int SR_WIDTH = SR_WIDTH_DEF,
    parameter int IR_WIDTH = IR_WIDTH_DEF,
    parameter int TCK_DIV  = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    nios2_debug_scan_master_if.master      bus
);
    localparam int              CNT_W    = bit_cnt_width(SR_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SR_WIDTH - 1);

    scan_state_e         r_state, w_next;
    logic                w_run, w_tck, w_rise, w_fall, w_last;
    logic                w_accept, w_skip_ir, w_bit_done;
    logic [CNT_W-1:0]    r_bit;
    logic [SR_WIDTH-1:0] r_shift;
    logic [SR_WIDTH-1:0] r_rsp_data;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_rsp_ir;
    logic                r_tdi;

    assign w_run      = r_state inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR};
    assign w_accept   = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_bit_done = (r_bit == LAST_BIT);

    nios2_debug_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_run   (w_run),
        .o_tck   (w_tck),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_last  (w_last)
    );

`ifdef NIOS2_DEBUG_SCAN_SKIP_IR_EN
    logic [IR_WIDTH-1:0] r_last_ir;
    logic                r_last_vld;

    // Only a completed update-IR makes the slave's IR known; an aborted scan clears it via reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_ir  <= '0;
            r_last_vld <= 1'b0;
        end else if ((r_state == ST_UIR) && w_last) begin
            r_last_ir  <= r_ir;
            r_last_vld <= 1'b1;
        end
    end

    assign w_skip_ir = r_last_vld && (bus.cmd_ir == r_last_ir);
`else
    assign w_skip_ir = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.cmd_valid) w_next = w_skip_ir ? ST_CDR : ST_UIR;
            ST_UIR:  if (w_last) w_next = ST_CDR;
            ST_CDR:  if (w_last) w_next = ST_SDR;
            ST_SDR:  if (w_last && w_bit_done) w_next = ST_UDR;
            ST_UDR:  if (w_last) w_next = ST_RSP;
            ST_RSP:  if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outgoing data shifts right so bit 0 is always the next tdi; captured tdo enters at the
    // MSB so that after SR_WIDTH shifts the first captured bit sits in bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit      <= '0;
            r_shift    <= '0;
            r_rsp_data <= '0;
            r_ir       <= '0;
            r_rsp_ir   <= '0;
            r_tdi      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ir    <= bus.cmd_ir;
                r_shift <= bus.cmd_data;
                r_bit   <= '0;
            end
            if ((r_state == ST_UIR) && w_rise) begin
                r_rsp_ir <= bus.vjm_ir_out;
            end
            if (r_state == ST_SDR) begin
                if (w_fall) begin
                    r_tdi   <= r_shift[0];
                    r_shift <= r_shift >> 1;
                end
                if (w_rise) begin
                    r_rsp_data <= {bus.vjm_tdo, r_rsp_data[SR_WIDTH-1:1]};
                end
                if (w_last) begin
                    r_bit <= w_bit_done ? '0 : r_bit + 1'b1;
                    if (w_bit_done) begin
                        r_tdi <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.rsp_valid  = (r_state == ST_RSP);
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_ir_out = r_rsp_ir;
    assign bus.vjm_tck    = w_tck;
    assign bus.vjm_tdi    = r_tdi;
    assign bus.vjm_ir_in  = r_ir;
    assign bus.vjm_rti    = (r_state == ST_IDLE);
    assign bus.vjm_uir    = (r_state == ST_UIR);
    assign bus.vjm_cdr    = (r_state == ST_CDR);
    assign bus.vjm_sdr    = (r_state == ST_SDR);
    assign bus.vjm_udr    = (r_state == ST_UDR);

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// tb/tb_nios2_debug_scan_master.sv - self-checking bench for nios2_debug_scan_master
module tb_nios2_debug_scan_master;

    localparam int SR       = 38;
    localparam int IRW      = 2;
    localparam int TD       = 2;
    localparam int PER      = 2 * TD;
    localparam int LAT      = 1 + (SR + 3) * PER;
    localparam int LAT_SKIP = LAT - PER;

    typedef struct {
        logic [IRW-1:0] ir;
        logic [SR-1:0]  data;
        int             mode;      // 0: tdo=0, 1: tdo=1, 2: loopback of previous tdi
        logic [IRW-1:0] ir_out;
        logic [SR-1:0]  exp_data;
        logic [IRW-1:0] exp_ir;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    int             n_checks = 0;
    int             n_fail = 0;
    int             tdo_mode = 0;
    logic [IRW-1:0] ir_out_drv = '0;
    logic           lb_cap = 1'b0;
    logic           lb_tdo = 1'b0;
    vec_t           vecs[4];

    nios2_debug_scan_master_if #(.SR_WIDTH(SR), .IR_WIDTH(IRW)) bus ();

    nios2_debug_scan_master #(.SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_DIV(TD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One-stage slave shift register: captures on tck rise, presents on tck fall.
    always @(posedge bus.vjm_tck) lb_cap <= bus.vjm_tdi;
    always @(negedge bus.vjm_tck) lb_tdo <= lb_cap;

    assign bus.vjm_tdo    = (tdo_mode == 2) ? lb_tdo : (tdo_mode == 1);
    assign bus.vjm_ir_out = ir_out_drv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_cmd_ready"}, 64'(bus.cmd_ready), 1);
        check({p, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
        check({p, "_rsp_data"}, 64'(bus.rsp_data), 0);
        check({p, "_rsp_ir_out"}, 64'(bus.rsp_ir_out), 0);
        check({p, "_tck"}, 64'(bus.vjm_tck), 0);
        check({p, "_tdi"}, 64'(bus.vjm_tdi), 0);
        check({p, "_ir_in"}, 64'(bus.vjm_ir_in), 0);
        check({p, "_rti"}, 64'(bus.vjm_rti), 1);
        check({p, "_flags"}, 64'({bus.vjm_uir, bus.vjm_cdr, bus.vjm_sdr, bus.vjm_udr}), 0);
    endtask

    task automatic run_scan(input string p, input logic [IRW-1:0] ir, input logic [SR-1:0] data,
                            input int mode, input logic [IRW-1:0] ir_out,
                            input logic [SR-1:0] exp_data, input logic [IRW-1:0] exp_ir,
                            input int exp_lat, input int exp_uir, input int hold);
        int cyc, n_uir, n_cdr, n_sdr, n_udr, nb;
        logic [SR-1:0] tdi_word;
        logic prev_tck;
        cyc = 1; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; nb = 0;
        tdi_word = '0; prev_tck = 1'b0;
        tdo_mode = mode;
        ir_out_drv = ir_out;
        @(negedge clk);
        check({p, "_pre_ready"}, 64'(bus.cmd_ready), 1);
        bus.cmd_ir = ir;
        bus.cmd_data = data;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        // Accepted at the edge just passed; later changes to the command must not matter.
        bus.cmd_valid = 1'b0;
        bus.cmd_data = ~data;
        bus.cmd_ir = ~ir;
        while (!bus.rsp_valid && cyc < 1000) begin
            if (cyc == 2) check({p, "_ir_in"}, 64'(bus.vjm_ir_in), 64'(ir));
            if (bus.vjm_uir) n_uir++;
            if (bus.vjm_cdr) n_cdr++;
            if (bus.vjm_sdr) n_sdr++;
            if (bus.vjm_udr) n_udr++;
            if (bus.vjm_sdr && bus.vjm_tck && !prev_tck) begin
                if (nb < SR) tdi_word[nb] = bus.vjm_tdi;
                nb++;
            end
            prev_tck = bus.vjm_tck;
            @(negedge clk);
            cyc++;
        end
        check({p, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({p, "_uir_cycles"}, 64'(n_uir), 64'(exp_uir));
        check({p, "_cdr_cycles"}, 64'(n_cdr), 64'(PER));
        check({p, "_sdr_cycles"}, 64'(n_sdr), 64'(SR * PER));
        check({p, "_udr_cycles"}, 64'(n_udr), 64'(PER));
        check({p, "_tdi_bits"}, 64'(nb), 64'(SR));
        check({p, "_tdi_word"}, 64'(tdi_word), 64'(data));
        check({p, "_rsp_data"}, 64'(bus.rsp_data), 64'(exp_data));
        check({p, "_rsp_ir"}, 64'(bus.rsp_ir_out), 64'(exp_ir));
        check({p, "_rsp_flags"}, 64'({bus.vjm_rti, bus.vjm_uir, bus.vjm_cdr, bus.vjm_sdr, bus.vjm_udr}), 0);
        if (hold > 0) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data = data ^ 38'h15_5555_5555;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({p, "_hold_valid"}, 64'(bus.rsp_valid), 1);
                check({p, "_hold_ready"}, 64'(bus.cmd_ready), 0);
                check({p, "_hold_tck"}, 64'(bus.vjm_tck), 0);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check({p, "_post_valid"}, 64'(bus.rsp_valid), 0);
        check({p, "_post_ready"}, 64'(bus.cmd_ready), 1);
        check({p, "_post_rti"}, 64'(bus.vjm_rti), 1);
        check({p, "_post_data_held"}, 64'(bus.rsp_data), 64'(exp_data));
    endtask

    initial begin
        int n, cyc, seen;
        vecs[0] = '{2'b01, 38'h2A_5A5A_5A5A, 2, 2'b00, 38'h14_B4B4_B4B4, 2'b00};
        vecs[1] = '{2'b00, 38'h00_0000_0000, 1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10};
        vecs[2] = '{2'b10, 38'h3C_0F0F_1234, 0, 2'b01, 38'h00_0000_0000, 2'b01};
        vecs[3] = '{2'b11, 38'h00_0000_0001, 2, 2'b11, 38'h00_0000_0002, 2'b11};

        bus.cmd_valid = 1'b0;
        bus.cmd_ir = '0;
        bus.cmd_data = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", 64'(bus.cmd_ready), 1);
            check("idle_rti", 64'(bus.vjm_rti), 1);
            check("idle_tck", 64'(bus.vjm_tck), 0);
            check("idle_rsp_valid", 64'(bus.rsp_valid), 0);
        end

        for (int i = 0; i < 4; i++) begin
            run_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].data, vecs[i].mode,
                     vecs[i].ir_out, vecs[i].exp_data, vecs[i].exp_ir, LAT, PER, 0);
        end

        run_scan("hold", 2'b01, 38'h01_2345_6789, 1, 2'b11, 38'h3F_FFFF_FFFF, 2'b11, LAT, PER, 20);

        // Abort in the middle of SDR bit 17.
        tdo_mode = 1;
        @(negedge clk);
        bus.cmd_ir = 2'b10;
        bus.cmd_data = 38'h2A_AAAA_AAAA;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 17 * PER + 2 && cyc < 400) begin
            if (bus.vjm_sdr) n++;
            @(negedge clk);
            cyc++;
        end
        check("abort_in_sdr", 64'(bus.vjm_sdr), 1);
        reset_n = 1'b0;
        #1;
        check_reset("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.cmd_ready) seen++;
        end
        check("abort_no_rsp", 64'(seen), 0);

        run_scan("after_abort", 2'b10, 38'h15_A5A5_A5A5, 1, 2'b01, 38'h3F_FFFF_FFFF, 2'b01, LAT, PER, 0);

`ifdef NIOS2_DEBUG_SCAN_SKIP_IR_EN
        run_scan("skip_first", 2'b11, 38'h0F_0F0F_0F0F, 0, 2'b10, 38'h00_0000_0000, 2'b10, LAT, PER, 0);
        run_scan("skip_second", 2'b11, 38'h30_F0F0_F0F0, 1, 2'b01, 38'h3F_FFFF_FFFF, 2'b10, LAT_SKIP, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
